cpu_trace_capture: RTL and testbench
====================================

// Module: cpu_trace_capture
// PURPOSE
// - Debug trace unit directly downstream of the single-cycle Cpu debug ports: samples debug_pc and debug_rf_data each clk.
// - Drives debug_dm_rf_addr to select the watched register.
// - Buffers {cycle, pc, rf_data} records in a circular FIFO and streams them out over a valid/ready port for on-board readout.
// - Replaces per-cycle file dumping on hardware; optional PC trigger starts capture.
// PARAMETERS
// - DEPTH        16  FIFO entries; power of 2, >=2; AW=log2(DEPTH)
// - STOP_ON_FULL 1   1: FIFO full ends capture (-> DONE); 0: samples dropped while full, capture continues
// PORTS
// - clk              in   1   system clock; all logic on posedge
// - rst              in   1   synchronous reset, active-high
// - start            in   1   1-cycle pulse; accepted only in IDLE or DONE
// - abort            in   1   force state to IDLE; FIFO contents kept
// - trig_en          in   1   1: wait for trig_pc; 0: capture immediately
// - trig_pc          in   32  trigger PC value
// - cap_len          in   16  records to capture; 0 = unlimited (until full/abort)
// - watch_addr       in   8   register/DM address to watch, latched on accepted start
// - cpu_pc           in   32  from Cpu debug_pc
// - cpu_rf_data      in   32  from Cpu debug_rf_data
// - debug_dm_rf_addr out  8   to Cpu; registered copy of watch_addr
// - out_valid        out  1   FIFO non-empty
// - out_ready        in   1   consumer accepts head record
// - out_cycle        out  16  head record: cycle index since capture start
// - out_pc           out  32  head record: pc
// - out_data         out  32  head record: rf data
// - state            out  2   0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
// - count            out  AW+1 FIFO occupancy
// - overflow         out  1   sticky: a sample was dropped because FIFO was full
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: state=IDLE; pointers, count, cycle counter, record counter = 0; overflow=0.
//   debug_dm_rf_addr=0; out_valid=0. FIFO RAM is not cleared.
// - Accepted start: clear FIFO pointers/count/overflow; latch watch_addr, trig_pc, cap_len.
//   Next state ARMED if trig_en, else CAPTURE.
// - ARMED: when cpu_pc==latched trig_pc, capture this cycle as record 0 (cycle=0) and go to CAPTURE.
// - CAPTURE: write one record per clk.
//   - Cycle counter is 0 at the first record and +1 each clk, wrapping at 16 bits; it advances every clk even when the write is skipped.
//   - Entered without trigger: first record is the sample in the cycle after start.
// - Record counter +1 per written record. When it reaches cap_len (cap_len!=0), go to DONE in the same cycle as the last write.
// - Full (count==DEPTH, pre-edge value): the write is blocked even if a read happens the same cycle.
//   Set overflow; if STOP_ON_FULL, go to DONE.
// - Read: FWFT. out_* = mem[rd_ptr] combinationally. A pop occurs when out_valid && out_ready. Pointers wrap mod DEPTH.
// - Simultaneous push+pop with 0<count<DEPTH: count unchanged. Pop on empty: ignored.
// - Latency: a sample written at edge k is visible on out_* with out_valid=1 after edge k.
// - DONE: hold until start. The FIFO stays readable in DONE and IDLE.
// - Priority, highest first: rst > abort > start > trigger/capture logic.
//   start in ARMED or CAPTURE is ignored; abort with start in the same cycle gives IDLE.
// CONFIGURATION
// - TRACE_CHANGE_ONLY_EN defined:
//   - In CAPTURE, write only when cpu_rf_data != last written data.
//   - The first record after start is always written. The cycle counter still counts every clk.
//   - Skipped samples do not count toward cap_len and do not set overflow.
// - TRACE_CHANGE_ONLY_EN undefined: every CAPTURE cycle attempts a write.
// TESTING
// - Reset mid-CAPTURE with 5 records buffered -> next cycle state=0, count=0, out_valid=0, overflow=0, debug_dm_rf_addr=0.
// - trig_en=0, cap_len=4, watch_addr=6, out_ready=0, pc 0,4,8,12 -> 4 records with cycle 0..3 and pc 0,4,8,12.
//   After the 4th write: state=3, debug_dm_rf_addr=6.
// - trig_en=1, trig_pc=0x20, pc steps by 4 from 0 -> state=1 until pc=0x20; first record is {0, 0x20, data}.
// - DEPTH=16, cap_len=0, STOP_ON_FULL=1, out_ready=0 -> count=16, overflow=1, state=3 on the 17th sample; head record has cycle=0.
// - Full FIFO, STOP_ON_FULL=0, out_ready=1 for one cycle -> no write that cycle, count=15.
//   Next sample is written; overflow=1.
// - TRACE_CHANGE_ONLY_EN, data 5,5,7,7,7,9 -> records (0,5),(2,7),(5,9); count=3.

Source files
------------

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: on-board trace buffer for the single-cycle Cpu debug ports.
// Samples {cycle, pc, rf_data} into a circular first-word-fall-through FIFO.
// Capture starts right after start, or on a PC match when triggering is enabled.
// Records stream out over a valid/ready port and stay readable in IDLE and DONE.
// Build option: define TRACE_CHANGE_ONLY_EN to record a sample only when the
// watched register value differs from the last recorded one.
module cpu_trace_capture #(
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  input  logic [15:0]   cap_len,
  input  logic [7:0]    watch_addr,
  input  logic [31:0]   cpu_pc,
  input  logic [31:0]   cpu_rf_data,
  output logic [7:0]    debug_dm_rf_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_cycle,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_data,
  output logic [1:0]    state,
  output logic [AW:0]   count,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } CapState;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  CapState       state_q;
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [15:0]   cycle_q;
  logic [15:0]   rec_q;
  logic [15:0]   capLen_q;
  logic [31:0]   trigPc_q;
  logic [7:0]    watch_q;
  logic [79:0]   mem_q [DEPTH];
`ifdef TRACE_CHANGE_ONLY_EN
  logic          first_q;
  logic [31:0]   lastData_q;
`endif

  logic        full;
  logic        popEn;
  logic        startAcc;
  logic        trigHit;
  logic        changeOk;
  logic        attempt;
  logic        pushEn;
  logic        blocked;
  logic        lastRec;
  logic [15:0] recNext;

  // Decode this cycle's start, trigger, push and pop events from registered state
  always_comb begin
    full     = (count_q == FULL_COUNT);
    popEn    = (count_q != '0) && out_ready;
    startAcc = start && !abort && ((state_q == IDLE) || (state_q == DONE));
    trigHit  = !abort && (state_q == ARMED) && (cpu_pc == trigPc_q);
`ifdef TRACE_CHANGE_ONLY_EN
    changeOk = first_q || (cpu_rf_data != lastData_q);
`else
    changeOk = 1'b1;
`endif
    attempt  = trigHit || (!abort && (state_q == CAPTURE) && changeOk);
    pushEn   = attempt && !full;
    blocked  = attempt && full;
    recNext  = rec_q + 16'd1;
    lastRec  = pushEn && (capLen_q != '0) && (recNext == capLen_q);
  end

  // Control FSM together with FIFO pointers, occupancy and capture counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      rec_q      <= '0;
      capLen_q   <= '0;
      trigPc_q   <= '0;
      watch_q    <= '0;
    end else begin
      if (abort) begin
        state_q <= IDLE;
      end else if (startAcc) begin
        state_q <= trig_en ? ARMED : CAPTURE;
      end else if (lastRec || (blocked && STOP_ON_FULL)) begin
        state_q <= DONE;
      end else if (trigHit) begin
        state_q <= CAPTURE;
      end

      if (startAcc) begin
        watch_q  <= watch_addr;
        trigPc_q <= trig_pc;
        capLen_q <= cap_len;
      end

      if (startAcc) begin
        wrPtr_q    <= '0;
        rdPtr_q    <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        rec_q      <= '0;
      end else begin
        if (pushEn) begin
          wrPtr_q <= wrPtr_q + 1'b1;
          rec_q   <= recNext;
        end
        if (popEn) begin
          rdPtr_q <= rdPtr_q + 1'b1;
        end
        if (pushEn && !popEn) begin
          count_q <= count_q + 1'b1;
        end else if (!pushEn && popEn) begin
          count_q <= count_q - 1'b1;
        end
        if (blocked) begin
          overflow_q <= 1'b1;
        end
      end

      if (startAcc) begin
        cycle_q <= '0;
      end else if (!abort && ((state_q == CAPTURE) || trigHit)) begin
        cycle_q <= cycle_q + 16'd1;
      end
    end
  end

`ifdef TRACE_CHANGE_ONLY_EN
  // Remember the last value actually written so repeated samples are skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= 1'b1;
      lastData_q <= '0;
    end else if (startAcc) begin
      first_q <= 1'b1;
    end else if (pushEn) begin
      first_q    <= 1'b0;
      lastData_q <= cpu_rf_data;
    end
  end
`endif

  // Record storage; contents survive reset and are simply overwritten
  always_ff @(posedge clk) begin
    if (!rst && pushEn) begin
      mem_q[wrPtr_q] <= {cycle_q, cpu_pc, cpu_rf_data};
    end
  end

  assign {out_cycle, out_pc, out_data} = mem_q[rdPtr_q];
  assign out_valid        = (count_q != '0);
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign state            = state_q;
  assign debug_dm_rf_addr = watch_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Testbench for cpu_trace_capture: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model of the trace
// unit. A second instance built with STOP_ON_FULL=0 covers the drop-while-full
// behaviour. Honours TRACE_CHANGE_ONLY_EN when the build defines it.
module tb_cpu_trace_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [15:0] cap_len;
  logic [7:0]  watch_addr;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_rf_data;
  logic        out_ready;

  logic [7:0]  dbgAddr;
  logic        outValid;
  logic [15:0] outCycle;
  logic [31:0] outPc;
  logic [31:0] outData;
  logic [1:0]  stateO;
  logic [4:0]  countO;
  logic        overflowO;

  logic [7:0]  dbgAddrB;
  logic        outValidB;
  logic [15:0] outCycleB;
  logic [31:0] outPcB;
  logic [31:0] outDataB;
  logic [1:0]  stateB;
  logic [4:0]  countB;
  logic        overflowB;

  cpu_trace_capture #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_en(trig_en),
    .trig_pc(trig_pc), .cap_len(cap_len), .watch_addr(watch_addr),
    .cpu_pc(cpu_pc), .cpu_rf_data(cpu_rf_data), .debug_dm_rf_addr(dbgAddr),
    .out_valid(outValid), .out_ready(out_ready), .out_cycle(outCycle),
    .out_pc(outPc), .out_data(outData), .state(stateO), .count(countO),
    .overflow(overflowO)
  );

  cpu_trace_capture #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) dutDrop (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_en(trig_en),
    .trig_pc(trig_pc), .cap_len(cap_len), .watch_addr(watch_addr),
    .cpu_pc(cpu_pc), .cpu_rf_data(cpu_rf_data), .debug_dm_rf_addr(dbgAddrB),
    .out_valid(outValidB), .out_ready(out_ready), .out_cycle(outCycleB),
    .out_pc(outPcB), .out_data(outDataB), .state(stateB), .count(countB),
    .overflow(overflowB)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cycle;
    logic [31:0] pc;
    logic [31:0] data;
  } TraceRec;

  TraceRec     mq[$];
  int          mState;
  int          mCycle;
  int          mRecs;
  int          mCapLen;
  bit          mOverflow;
  logic [31:0] mTrigPc;
  logic [7:0]  mWatch;
  bit          mFirst;
  logic [31:0] mLast;

  int checks = 0;
  int errors = 0;

  // Advance the reference model by one clock using the inputs about to be sampled
  task automatic modelStep();
    bit      isFull;
    bit      doPop;
    bit      hit;
    bit      wasCapture;
    bit      tryWrite;
    TraceRec r;
    isFull = (mq.size() == DEPTH);
    doPop  = (mq.size() != 0) && out_ready;
    if (rst) begin
      mState = 0; mq.delete(); mOverflow = 0; mCycle = 0; mRecs = 0;
      mCapLen = 0; mTrigPc = '0; mWatch = '0; mFirst = 1; mLast = '0;
      return;
    end
    if (abort) begin
      mState = 0;
      if (doPop) void'(mq.pop_front());
      return;
    end
    if (start && (mState == 0 || mState == 3)) begin
      mq.delete(); mOverflow = 0; mRecs = 0; mCycle = 0; mFirst = 1;
      mWatch = watch_addr; mTrigPc = trig_pc; mCapLen = int'(cap_len);
      mState = trig_en ? 1 : 2;
      return;
    end
    hit        = (mState == 1) && (cpu_pc == mTrigPc);
    wasCapture = (mState == 2);
`ifdef TRACE_CHANGE_ONLY_EN
    tryWrite = hit || (wasCapture && (mFirst || cpu_rf_data != mLast));
`else
    tryWrite = hit || wasCapture;
`endif
    if (doPop) void'(mq.pop_front());
    if (tryWrite) begin
      if (isFull) begin
        mOverflow = 1;
        mState = 3;
      end else begin
        r.cycle = 16'(mCycle);
        r.pc    = cpu_pc;
        r.data  = cpu_rf_data;
        mq.push_back(r);
        mRecs++;
        mFirst = 0;
        mLast  = cpu_rf_data;
        if (mCapLen != 0 && mRecs == mCapLen) mState = 3;
        else if (hit) mState = 2;
      end
    end
    if (hit || wasCapture) mCycle = (mCycle + 1) % 65536;
  endtask

  // Single comparison point with failure accounting
  task automatic checkOne(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every visible output of the main instance against the model
  task automatic checkOutput(string phase);
    checkOne({phase, ":state"},    32'(stateO),    32'(mState));
    checkOne({phase, ":count"},    32'(countO),    32'(mq.size()));
    checkOne({phase, ":valid"},    32'(outValid),  32'(mq.size() != 0));
    checkOne({phase, ":overflow"}, 32'(overflowO), 32'(mOverflow));
    checkOne({phase, ":addr"},     32'(dbgAddr),   32'(mWatch));
    if (mq.size() != 0) begin
      checkOne({phase, ":cycle"}, 32'(outCycle), 32'(mq[0].cycle));
      checkOne({phase, ":pc"},    outPc,         mq[0].pc);
      checkOne({phase, ":data"},  outData,       mq[0].data);
    end
  endtask

  // Apply the current inputs for one clock, then check away from the edge
  task automatic applyStimulus(string phase);
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput(phase);
  endtask

  // Directed scenarios then random traffic, all in one linear sequence
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_pc = '0;
    cap_len = '0; watch_addr = '0; cpu_pc = '0; cpu_rf_data = '0; out_ready = 1'b0;
    @(negedge clk);
    applyStimulus("reset");
    applyStimulus("reset");
    rst = 1'b0;

    // Untriggered capture of four records
    watch_addr = 8'd6; cap_len = 16'd4; trig_en = 1'b0; start = 1'b1;
    applyStimulus("start4");
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_pc = 32'(i * 4); cpu_rf_data = 32'(100 + i);
      applyStimulus("cap4");
    end
    checkOne("cap4:doneState", 32'(stateO),  32'd3);
    checkOne("cap4:addr6",     32'(dbgAddr), 32'd6);
    checkOne("cap4:count4",    32'(countO),  32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOne("drain:cycle", 32'(outCycle), 32'(i));
      checkOne("drain:pc",    outPc,         32'(i * 4));
      applyStimulus("drain");
    end
    out_ready = 1'b0;

    // PC-triggered capture
    trig_en = 1'b1; trig_pc = 32'h20; cap_len = 16'd3; cpu_pc = '0; start = 1'b1;
    applyStimulus("arm");
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpu_pc = 32'(i * 4); cpu_rf_data = 32'(200 + i);
      applyStimulus("armed");
      checkOne("armed:state", 32'(stateO), 32'd1);
    end
    cpu_pc = 32'h20; cpu_rf_data = 32'd208;
    applyStimulus("trigger");
    checkOne("trigger:cycle0", 32'(outCycle), 32'd0);
    checkOne("trigger:pc20",   outPc,         32'h20);
    checkOne("trigger:data",   outData,       32'd208);
    checkOne("trigger:state",  32'(stateO),   32'd2);
    for (int i = 0; i < 2; i++) begin
      cpu_pc = 32'h24 + 32'(i * 4); cpu_rf_data = 32'(209 + i);
      applyStimulus("trigTail");
    end

    // Fill to full with unlimited length and no reader
    trig_en = 1'b0; cap_len = '0; out_ready = 1'b0; start = 1'b1;
    applyStimulus("startFull");
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cpu_pc = 32'(i * 4); cpu_rf_data = 32'(300 + i);
      applyStimulus("fill");
    end
    checkOne("full:count16",  32'(countO),    32'd16);
    checkOne("full:overflow", 32'(overflowO), 32'd1);
    checkOne("full:done",     32'(stateO),    32'd3);
    checkOne("full:headCyc",  32'(outCycle),  32'd0);
    checkOne("drop:count16",  32'(countB),    32'd16);
    checkOne("drop:capture",  32'(stateB),    32'd2);
    checkOne("drop:overflow", 32'(overflowB), 32'd1);
    out_ready = 1'b1; cpu_pc = 32'h100; cpu_rf_data = 32'd400;
    applyStimulus("popFull");
    out_ready = 1'b0;
    checkOne("drop:popNoWrite", 32'(countB), 32'd15);
    cpu_pc = 32'h104; cpu_rf_data = 32'd401;
    applyStimulus("refill");
    checkOne("drop:refill",      32'(countB),    32'd16);
    checkOne("drop:overflowSty", 32'(overflowB), 32'd1);

    // Reset in the middle of a capture
    start = 1'b1;
    applyStimulus("startRst");
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_pc = 32'(i * 4); cpu_rf_data = 32'(500 + i);
      applyStimulus("fill5");
    end
    checkOne("fill5:count", 32'(countO), 32'd5);
    rst = 1'b1;
    applyStimulus("midReset");
    rst = 1'b0;
    checkOne("midReset:state",    32'(stateO),    32'd0);
    checkOne("midReset:count",    32'(countO),    32'd0);
    checkOne("midReset:valid",    32'(outValid),  32'd0);
    checkOne("midReset:overflow", 32'(overflowO), 32'd0);
    checkOne("midReset:addr",     32'(dbgAddr),   32'd0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 9) == 0);
      trig_en     = 1'($urandom_range(0, 1));
      trig_pc     = 32'($urandom_range(0, 15) * 4);
      cap_len     = 16'($urandom_range(0, 24));
      watch_addr  = 8'($urandom_range(0, 255));
      cpu_pc      = 32'($urandom_range(0, 15) * 4);
      cpu_rf_data = 32'($urandom_range(0, 3));
      out_ready   = ($urandom_range(0, 3) == 0);
      applyStimulus("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
